// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared constants and an elaboration-time helper for the debounce block.
//   The FSM state type and counter width are kept inside the debounce
//   module, because nothing else needs them.
package debounce_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 16;

    // A qualification window of zero samples has no meaning; callers use
    // this to reject such a configuration at elaboration time.
    function automatic bit stable_cycles_valid(input int n);
        return n >= 1;
    endfunction

endpackage

// File: rtl/debounce.sv
// debounce
//   Qualifies a slow, already-synchronized input. A new level is accepted
//   only after data_i has differed from data_o for STABLE_CYCLES consecutive
//   clocks. On acceptance a one-cycle rise or fall strobe is emitted. All
//   outputs come straight from flops.
//
// Ports
//   clock_i  in   system clock, posedge
//   reset_i  in   asynchronous, active-high reset
//   data_i   in   synchronized input (clock_i domain)
//   data_o   out  debounced level
//   rise_o   out  one-cycle strobe on accepted 0->1
//   fall_o   out  one-cycle strobe on accepted 1->0
//   busy_o   out  high while a candidate change is being qualified
//
// State table
//   state   | meaning
//   IDLE    | data_i matches data_o, counter at zero
//   QUALIFY | data_i differs from data_o, counting consecutive mismatches
module debounce
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic INITIAL_DATA  = 1'b0
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic data_i,
    output logic data_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    generate
        if (!stable_cycles_valid(STABLE_CYCLES)) begin : g_bad_cfg
            $error("debounce: STABLE_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic {
        IDLE    = 1'b0,
        QUALIFY = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             data_q, data_n;
    logic             rise_q, rise_n;
    logic             fall_q, fall_n;
    logic             busy_q, busy_n;

    logic             mismatch;
    logic             last_sample;
    logic [CNT_W-1:0] cnt_inc;

    assign mismatch    = (data_i != data_q);
    // True when the sample on this edge completes the qualification window.
    assign last_sample = (({1'b0, cnt} + 1'b1) == (CNT_W + 1)'(STABLE_CYCLES));
    // Saturate rather than wrap, so a stuck counter can never alias to a
    // short window.
    assign cnt_inc     = (cnt == CNT_W'(STABLE_CYCLES)) ? cnt : cnt + 1'b1;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state  <= IDLE;
            cnt    <= '0;
            data_q <= INITIAL_DATA;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            data_q <= data_n;
            rise_q <= rise_n;
            fall_q <= fall_n;
            busy_q <= busy_n;
        end
    end

    always_comb begin
        logic accept;
        state_n = state;
        cnt_n   = cnt;
        data_n  = data_q;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        accept  = 1'b0;

        case (state)
            IDLE: begin
                if (mismatch) begin
                    if (STABLE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        cnt_n   = CNT_W'(1);
                        state_n = QUALIFY;
                    end
                end
            end
            QUALIFY: begin
                if (!mismatch) begin
                    // Bounce back to the old level: drop the candidate.
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (last_sample) begin
                    accept = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase

        if (accept) begin
            data_n  = data_i;
            rise_n  = data_i;
            fall_n  = ~data_i;
            cnt_n   = '0;
            state_n = IDLE;
        end

        busy_n = (state_n == QUALIFY);
    end

    assign data_o = data_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_debounce.sv
// tb_debounce
//   Directed bench for debounce. Two instances: STABLE_CYCLES=4 and
//   STABLE_CYCLES=1, both with INITIAL_DATA=0. The driver pushes the
//   expected {data,rise,fall,busy} for the next clock edge into a queue,
//   tagged with that edge's cycle number; a monitor pops and compares
//   just after each edge.
module tb_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, din4, data4, rise4, fall4, busy4;
    logic rst1, din1, data1, rise1, fall1, busy1;

    debounce #(.STABLE_CYCLES(4), .INITIAL_DATA(1'b0)) dut4 (
        .clock_i (clk),
        .reset_i (rst4),
        .data_i  (din4),
        .data_o  (data4),
        .rise_o  (rise4),
        .fall_o  (fall4),
        .busy_o  (busy4)
    );

    debounce #(.STABLE_CYCLES(1), .INITIAL_DATA(1'b0)) dut1 (
        .clock_i (clk),
        .reset_i (rst1),
        .data_i  (din1),
        .data_o  (data1),
        .rise_o  (rise1),
        .fall_o  (fall1),
        .busy_o  (busy1)
    );

    wire [3:0] out4 = {data4, rise4, fall4, busy4};
    wire [3:0] out1 = {data1, rise1, fall1, busy1};

    typedef struct {
        int         cyc;
        bit         sel;
        logic [3:0] exp;
        string      tag;
    } exp_t;

    exp_t  sb[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    string tag = "init";

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got {data,rise,fall,busy}=%b, expected %b (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Drive one sample after the edge and record what the next edge must produce.
    task automatic step(input bit sel, input logic din, input logic [3:0] exp);
        exp_t e;
        @(posedge clk);
        #2;
        if (sel) begin
            rst1 = 1'b0;
            din1 = din;
        end else begin
            rst4 = 1'b0;
            din4 = din;
        end
        e.cyc = cyc + 1;
        e.sel = sel;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d",
                         e.tag, e.cyc, cyc);
            end else begin
                check(e.tag, e.sel ? out1 : out4, e.exp);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, required < 20000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst4 = 1'b1;
        rst1 = 1'b1;
        din4 = 1'b1;
        din1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset4_state", out4, 4'b0000);
        check("reset1_state", out1, 4'b0000);

        // 1: input held high through reset, released
        tag = "release_rise";
        step(0, 1'b1, 4'b0001);
        step(0, 1'b1, 4'b0001);
        step(0, 1'b1, 4'b0001);
        step(0, 1'b1, 4'b1100);
        step(0, 1'b1, 4'b1000);

        // 4: falling change from steady high
        tag = "fall";
        step(0, 1'b0, 4'b1001);
        step(0, 1'b0, 4'b1001);
        step(0, 1'b0, 4'b1001);
        step(0, 1'b0, 4'b0010);
        step(0, 1'b0, 4'b0000);

        // 2: three-cycle pulse is rejected
        tag = "short_pulse";
        step(0, 1'b1, 4'b0001);
        step(0, 1'b1, 4'b0001);
        step(0, 1'b1, 4'b0001);
        step(0, 1'b0, 4'b0000);
        step(0, 1'b0, 4'b0000);

        // 3: bounce restarts qualification
        tag = "bounce";
        step(0, 1'b1, 4'b0001);
        step(0, 1'b1, 4'b0001);
        step(0, 1'b0, 4'b0000);
        step(0, 1'b1, 4'b0001);
        step(0, 1'b1, 4'b0001);
        step(0, 1'b1, 4'b0001);
        step(0, 1'b1, 4'b1100);
        step(0, 1'b1, 4'b1000);

        tag = "fall_again";
        step(0, 1'b0, 4'b1001);
        step(0, 1'b0, 4'b1001);
        step(0, 1'b0, 4'b1001);
        step(0, 1'b0, 4'b0010);
        step(0, 1'b0, 4'b0000);

        // 5: asynchronous reset mid-qualification
        tag = "pre_reset";
        step(0, 1'b1, 4'b0001);
        step(0, 1'b1, 4'b0001);
        @(posedge clk);
        #5;
        rst4 = 1'b1;
        #1;
        check("async_reset_now", out4, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check("async_reset_held", out4, 4'b0000);
        tag = "post_reset";
        step(0, 1'b1, 4'b0001);
        step(0, 1'b1, 4'b0001);
        step(0, 1'b1, 4'b0001);
        step(0, 1'b1, 4'b1100);
        step(0, 1'b1, 4'b1000);

        // 6: STABLE_CYCLES=1 follows a toggling input one edge later
        tag = "fast_toggle";
        step(1, 1'b1, 4'b1100);
        step(1, 1'b0, 4'b0010);
        step(1, 1'b1, 4'b1100);
        step(1, 1'b0, 4'b0010);
        step(1, 1'b0, 4'b0000);

        repeat (3) @(posedge clk);
        #3;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
